// File: rtl/mandelbrot_ctx_engine.sv
// Multi-context Mandelbrot escape-time engine.
// Round-robins one iteration step per cycle across NUM_CTX pixel contexts.
module mandelbrot_ctx_engine #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int NUM_CTX         = 4,
    parameter int TAG_WIDTH       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         soft_clear_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] x0_i,
    input  logic signed [DATA_WIDTH-1:0] y0_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
    input  logic [DATA_WIDTH-1:0]        escape_r2_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [MAX_ITER_WIDTH-1:0]    iter_o,
    output logic                         escaped_o,
    output logic [TAG_WIDTH-1:0]         tag_o,
    output logic                         busy_o
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam logic signed [2*DW-1:0] SMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {S_FREE, S_RUN, S_DONE} ctx_state_t;

    ctx_state_t                r_state [NUM_CTX];
    logic [DW-1:0]             r_x     [NUM_CTX];
    logic [DW-1:0]             r_y     [NUM_CTX];
    logic [DW-1:0]             r_x0    [NUM_CTX];
    logic [DW-1:0]             r_y0    [NUM_CTX];
    logic [DW-1:0]             r_r2    [NUM_CTX];
    logic [MAX_ITER_WIDTH-1:0] r_iter  [NUM_CTX];
    logic [MAX_ITER_WIDTH-1:0] r_max   [NUM_CTX];
    logic [TAG_WIDTH-1:0]      r_tag   [NUM_CTX];
    logic                      r_esc   [NUM_CTX];
    logic [PW-1:0]             r_ptr;

    logic                      r_out_valid;
    logic [MAX_ITER_WIDTH-1:0] r_out_iter;
    logic                      r_out_esc;
    logic [TAG_WIDTH-1:0]      r_out_tag;

    logic          w_free_any, w_done_any, w_ctx_busy;
    logic [PW-1:0] w_free_idx, w_done_idx;

    // Descending scan so the lowest index wins.
    always_comb begin
        w_free_any = 1'b0;
        w_done_any = 1'b0;
        w_ctx_busy = 1'b0;
        w_free_idx = '0;
        w_done_idx = '0;
        for (int i = NUM_CTX - 1; i >= 0; i--) begin
            if (r_state[i] == S_FREE) begin
                w_free_any = 1'b1;
                w_free_idx = PW'(i);
            end else begin
                w_ctx_busy = 1'b1;
            end
            if (r_state[i] == S_DONE) begin
                w_done_any = 1'b1;
                w_done_idx = PW'(i);
            end
        end
    end

    logic [DW-1:0]          w_vx, w_vy, w_x2, w_y2, w_xy, w_nx, w_ny;
    logic signed [2*DW-1:0] w_ex, w_ey, w_pxx, w_pyy, w_pxy, w_sxx, w_syy;
    logic [DW:0]            w_mag;
    logic                   w_visit, w_esc, w_more, w_accept, w_out_load;

    assign w_vx  = r_x[r_ptr];
    assign w_vy  = r_y[r_ptr];
    assign w_ex  = $signed({{DW{w_vx[DW-1]}}, w_vx});
    assign w_ey  = $signed({{DW{w_vy[DW-1]}}, w_vy});
    assign w_pxx = w_ex * w_ex;
    assign w_pyy = w_ey * w_ey;
    assign w_pxy = w_ex * w_ey;
    assign w_sxx = w_pxx >>> FRACTIONAL_BITS;
    assign w_syy = w_pyy >>> FRACTIONAL_BITS;
    assign w_x2  = (w_sxx > SMAX) ? SMAX[DW-1:0] : w_sxx[DW-1:0];
    assign w_y2  = (w_syy > SMAX) ? SMAX[DW-1:0] : w_syy[DW-1:0];
    assign w_xy  = DW'(w_pxy >>> FRACTIONAL_BITS);
    assign w_mag = {1'b0, w_x2} + {1'b0, w_y2};
    assign w_nx  = w_x2 - w_y2 + r_x0[r_ptr];
    assign w_ny  = {w_xy[DW-2:0], 1'b0} + r_y0[r_ptr];

    assign w_visit    = (r_state[r_ptr] == S_RUN);
    assign w_esc      = w_mag > {1'b0, r_r2[r_ptr]};
    assign w_more     = r_iter[r_ptr] < r_max[r_ptr];
    assign w_accept   = in_valid_i && w_free_any && !soft_clear_i;
    assign w_out_load = !r_out_valid || out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                r_state[i] <= S_FREE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_x0[i]    <= '0;
                r_y0[i]    <= '0;
                r_r2[i]    <= '0;
                r_iter[i]  <= '0;
                r_max[i]   <= '0;
                r_tag[i]   <= '0;
                r_esc[i]   <= 1'b0;
            end
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_iter  <= '0;
            r_out_esc   <= 1'b0;
            r_out_tag   <= '0;
        end else begin
            r_ptr <= (r_ptr == PW'(NUM_CTX - 1)) ? '0 : r_ptr + 1'b1;
            if (soft_clear_i) begin
                for (int i = 0; i < NUM_CTX; i++) r_state[i] <= S_FREE;
                r_out_valid <= 1'b0;
            end else begin
                if (w_visit) begin
                    if (w_esc) begin
                        r_state[r_ptr] <= S_DONE;
                        r_esc[r_ptr]   <= 1'b1;
                    end else if (w_more) begin
                        r_x[r_ptr]    <= w_nx;
                        r_y[r_ptr]    <= w_ny;
                        r_iter[r_ptr] <= r_iter[r_ptr] + 1'b1;
                    end else begin
                        r_state[r_ptr] <= S_DONE;
                        r_esc[r_ptr]   <= 1'b0;
                    end
                end
                if (w_accept) begin
                    r_state[w_free_idx] <= S_RUN;
                    r_x[w_free_idx]     <= x0_i;
                    r_y[w_free_idx]     <= y0_i;
                    r_x0[w_free_idx]    <= x0_i;
                    r_y0[w_free_idx]    <= y0_i;
                    r_r2[w_free_idx]    <= escape_r2_i;
                    r_iter[w_free_idx]  <= MAX_ITER_WIDTH'(1);
                    r_max[w_free_idx]   <= max_iter_i;
                    r_tag[w_free_idx]   <= tag_i;
                end
                if (w_out_load) begin
                    r_out_valid <= w_done_any;
                    if (w_done_any) begin
                        r_out_iter          <= r_iter[w_done_idx];
                        r_out_esc           <= r_esc[w_done_idx];
                        r_out_tag           <= r_tag[w_done_idx];
                        r_state[w_done_idx] <= S_FREE;
                    end
                end
            end
        end
    end

    assign in_ready_o  = w_free_any;
    assign out_valid_o = r_out_valid;
    assign iter_o      = r_out_iter;
    assign escaped_o   = r_out_esc;
    assign tag_o       = r_out_tag;
    assign busy_o      = w_ctx_busy || r_out_valid;
endmodule

// File: tb/tb_mandelbrot_ctx_engine.sv
// Bench for mandelbrot_ctx_engine: 4-context and 1-context instances,
// escape-time reference model with a tag-keyed scoreboard.
module tb_mandelbrot_ctx_engine;
    localparam logic [31:0] ONE = 32'h0100_0000;
    localparam logic [31:0] R4  = 32'h0400_0000;

    logic clk = 1'b0;
    logic rst, soft_clear, in_valid, out_ready;
    logic signed [31:0] x0, y0;
    logic [15:0] tag, max_iter;
    logic [31:0] r2;

    logic        o4_in_ready, o4_valid, o4_esc, o4_busy;
    logic [15:0] o4_iter, o4_tag;
    logic        o1_in_ready, o1_valid, o1_esc, o1_busy;
    logic [15:0] o1_iter, o1_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mandelbrot_ctx_engine #(.NUM_CTX(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .soft_clear_i(soft_clear),
        .in_valid_i(in_valid), .in_ready_o(o4_in_ready),
        .x0_i(x0), .y0_i(y0), .tag_i(tag), .max_iter_i(max_iter),
        .escape_r2_i(r2), .out_valid_o(o4_valid), .out_ready_i(out_ready),
        .iter_o(o4_iter), .escaped_o(o4_esc), .tag_o(o4_tag), .busy_o(o4_busy)
    );

    mandelbrot_ctx_engine #(.NUM_CTX(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .soft_clear_i(soft_clear),
        .in_valid_i(in_valid), .in_ready_o(o1_in_ready),
        .x0_i(x0), .y0_i(y0), .tag_i(tag), .max_iter_i(max_iter),
        .escape_r2_i(r2), .out_valid_o(o1_valid), .out_ready_i(out_ready),
        .iter_o(o1_iter), .escaped_o(o1_esc), .tag_o(o1_tag), .busy_o(o1_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Escape-time reference: returns {escaped, iter}.
    function automatic logic [16:0] model(input logic signed [31:0] cx, input logic signed [31:0] cy,
                                          input logic [15:0] mx, input logic [31:0] rr);
        longint x, y, x2, y2, xy, lim;
        int it;
        x = cx;
        y = cy;
        it = 1;
        lim = longint'({32'b0, rr});
        for (int n = 0; n < 70000; n++) begin
            x2 = (x * x) >>> 24;
            y2 = (y * y) >>> 24;
            if (x2 > 64'sh7FFF_FFFF) x2 = 64'sh7FFF_FFFF;
            if (y2 > 64'sh7FFF_FFFF) y2 = 64'sh7FFF_FFFF;
            xy = longint'(int'((x * y) >>> 24));
            if (x2 + y2 > lim) return {1'b1, 16'(it)};
            if (it >= int'(mx)) return {1'b0, 16'(it)};
            x = longint'(int'(x2 - y2 + cx));
            y = longint'(int'(2 * xy + cy));
            it++;
        end
        return '0;
    endfunction

    logic [16:0] exp_tab [logic [15:0]];
    logic [15:0] q_tag[$];
    logic [15:0] q_iter[$];
    logic        stall_prev = 1'b0;
    logic [15:0] h_iter, h_tag;
    logic        h_esc;

    always @(negedge clk) begin
        if (rst || soft_clear) begin
            exp_tab.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold_out", {o4_valid, o4_iter, o4_esc, o4_tag}, {1'b1, h_iter, h_esc, h_tag});
            if (o4_valid && out_ready) begin
                chk("sb_known_tag", 64'(exp_tab.exists(o4_tag)), 64'd1);
                if (exp_tab.exists(o4_tag)) begin
                    chk("sb_result", {o4_esc, o4_iter}, exp_tab[o4_tag]);
                    exp_tab.delete(o4_tag);
                end
                q_tag.push_back(o4_tag);
                q_iter.push_back(o4_iter);
            end
            if (in_valid && o4_in_ready) exp_tab[tag] = model(x0, y0, max_iter, r2);
            stall_prev = o4_valid && !out_ready;
            h_iter = o4_iter;
            h_esc  = o4_esc;
            h_tag  = o4_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [31:0] x, input logic [31:0] y, input int mx, input int t);
        x0 = x;
        y0 = y;
        max_iter = 16'(mx);
        tag = 16'(t);
        r2 = R4;
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_valid"}, o4_valid, 0);
        chk({n, "_iter"}, o4_iter, 0);
        chk({n, "_esc"}, o4_esc, 0);
        chk({n, "_tag"}, o4_tag, 0);
        chk({n, "_busy"}, o4_busy, 0);
        chk({n, "_in_ready"}, o4_in_ready, 1);
        chk({n, "_valid1"}, o1_valid, 0);
        chk({n, "_busy1"}, o1_busy, 0);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!o4_busy && !o1_busy) break;
        end
        chk("drain_idle", {o4_busy, o1_busy}, 0);
        tick();
    endtask

    // Single pixel through the 1-context instance; latency counted in edges after accept.
    task automatic run1(input string n, input logic [31:0] x, input logic [31:0] y, input int mx,
                        input int t, input int e_lat, input int e_iter, input logic e_esc);
        int k;
        set_px(x, y, mx, t);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (k < 500) begin
            @(negedge clk);
            if (o1_valid) break;
            @(posedge clk);
            k++;
        end
        chk({n, "_latency"}, 64'(k), 64'(e_lat));
        chk({n, "_iter"}, o1_iter, 16'(e_iter));
        chk({n, "_esc"}, o1_esc, e_esc);
        chk({n, "_tag"}, o1_tag, 16'(t));
        drain();
    endtask

    logic [31:0] tx [4];
    logic [31:0] ty [4];
    int          tm [4];
    int          acc;

    initial begin
        rst = 1'b1;
        soft_clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_px(0, 0, 0, 0);
        #1;
        chk_reset("reset");
        tick();
        tick();
        chk_reset("reset_hold");
        rst = 1'b0;
        tick();

        chk("model_zero", model(0, 0, 20, R4), {1'b0, 16'd20});
        chk("model_22", model(2 * ONE, 2 * ONE, 50, R4), {1'b1, 16'd1});
        chk("model_one", model(ONE, 0, 50, R4), {1'b1, 16'd3});
        chk("model_m2", model(-2 * ONE, 0, 50, R4), {1'b0, 16'd50});
        chk("model_max0", model(0, 0, 0, R4), {1'b0, 16'd1});

        run1("c00", 0, 0, 20, 1, 21, 20, 1'b0);
        run1("c22", 2 * ONE, 2 * ONE, 20, 2, 2, 1, 1'b1);
        run1("c10", ONE, 0, 50, 3, 4, 3, 1'b1);
        run1("cm20", -2 * ONE, 0, 50, 4, 51, 50, 1'b0);
        run1("max0", 0, 0, 0, 5, 2, 1, 1'b0);

        // Four contexts, mixed run lengths: results leave out of order.
        tx = '{0, 2 * ONE, ONE, 2 * ONE};
        ty = '{0, 2 * ONE, 0, 2 * ONE};
        q_tag.delete();
        q_iter.delete();
        for (int i = 0; i < 4; i++) begin
            set_px(tx[i], ty[i], 8, i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("order_count", 64'(q_tag.size()), 4);
        if (q_tag.size() == 4) begin
            chk("order_tag0", q_tag[0], 1);
            chk("order_tag1", q_tag[1], 3);
            chk("order_tag2", q_tag[2], 2);
            chk("order_tag3", q_tag[3], 0);
            chk("order_iter0", q_iter[0], 1);
            chk("order_iter1", q_iter[1], 1);
            chk("order_iter2", q_iter[2], 3);
            chk("order_iter3", q_iter[3], 8);
        end

        // Output stalled: contexts fill and back-pressure reaches the input.
        tx = '{2 * ONE, ONE, 0, -2 * ONE};
        ty = '{2 * ONE, 0, 0, 0};
        tm = '{8, 8, 6, 5};
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            set_px(tx[acc % 4], ty[acc % 4], tm[acc % 4], 40 + acc);
            in_valid = 1'b1;
            @(negedge clk);
            if (o4_in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("stall_accepts", 64'(acc), 5);
        repeat (60) tick();
        @(negedge clk);
        chk("stall_in_ready", o4_in_ready, 0);
        chk("stall_valid", o4_valid, 1);
        chk("stall_busy", o4_busy, 1);
        tick();
        q_tag.delete();
        q_iter.delete();
        out_ready = 1'b1;
        drain();
        chk("stall_release_count", 64'(q_tag.size()), 5);
        @(negedge clk);
        chk("stall_release_ready", o4_in_ready, 1);
        tick();

        // Soft clear mid-run beats a simultaneous accept.
        set_px(0, 0, 300, 60);
        in_valid = 1'b1;
        tick();
        set_px(0, 0, 300, 61);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        set_px(2 * ONE, 2 * ONE, 8, 62);
        in_valid = 1'b1;
        soft_clear = 1'b1;
        tick();
        soft_clear = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("sclr_valid", o4_valid, 0);
        chk("sclr_busy", o4_busy, 0);
        chk("sclr_in_ready", o4_in_ready, 1);
        chk("sclr_busy1", o1_busy, 0);
        repeat (5) tick();
        @(negedge clk);
        chk("sclr_no_accept", {o4_busy, o1_busy}, 0);
        tick();

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        set_px(2 * ONE, 2 * ONE, 8, 70);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("pre_rst_valid", o4_valid, 1);
        chk("pre_rst_tag", o4_tag, 70);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        run1("post_rst", 2 * ONE, 2 * ONE, 8, 71, 2, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mandelbrot_ctx_engine.md
Name: mandelbrot_ctx_engine

Overview:
- Multi-context Mandelbrot escape-time engine; successor to the single-pixel iteration core.
- Holds NUM_CTX independent pixels and round-robins one iteration step per cycle across them.
- Accepts pixels on a valid/ready stream; results leave on a separate valid/ready stream carrying a caller tag.
- Escape radius and iteration limit are latched per pixel.
- Sits between the pixel-coordinate generator and the colour/writeback stage.

Parameters:
INTEGER_BITS, 8, integer bits of signed fixed-point coordinates
FRACTIONAL_BITS, 24, fractional bits
DATA_WIDTH, INTEGER_BITS+FRACTIONAL_BITS, coordinate width
MAX_ITER_WIDTH, 16, iteration counter width
NUM_CTX, 4, pixel contexts (>=1)
TAG_WIDTH, 16, opaque pixel tag width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
soft_clear_i  in  1  synchronous abort of all work
in_valid_i  in  1  input pixel valid
in_ready_o  out  1  at least one FREE context
x0_i  in  DATA_WIDTH  signed real part of c
y0_i  in  DATA_WIDTH  signed imaginary part of c
tag_i  in  TAG_WIDTH  pixel tag
max_iter_i  in  MAX_ITER_WIDTH  iteration limit, latched at accept
escape_r2_i  in  DATA_WIDTH  unsigned squared escape radius, latched at accept
out_valid_o  out  1  result valid
out_ready_i  in  1  result accepted
iter_o  out  MAX_ITER_WIDTH  iteration count
escaped_o  out  1  1 = escaped, 0 = hit limit
tag_o  out  TAG_WIDTH  tag of result
busy_o  out  1  any context not FREE or output register valid

Behaviour:
- Reset (rst_i): asynchronous, active-high; clock is clk_i.
  - All contexts go FREE; output register is invalid; the schedule pointer is 0.
  - Output values during and after reset: out_valid_o=0, iter_o=0, escaped_o=0, tag_o=0, busy_o=0, in_ready_o=1.
- Context states: FREE -> RUN -> DONE -> FREE.
- Accept:
  - Occurs when in_valid_i && in_ready_o at a clock edge.
  - Target is the lowest-index FREE context. The context is loaded with z=c, iter=1, x0, y0, tag, max_iter and r2, and becomes RUN.
  - in_ready_o is combinational from the current context states. A slot freed at an edge is usable only from the next cycle.
- Schedule:
  - Pointer p increments mod NUM_CTX every cycle, unconditionally.
  - Each cycle, context p is visited only if it was RUN before the current edge. A context loaded at edge E is first eligible in the cycle after E.
- Visit arithmetic, in Q(INTEGER_BITS.FRACTIONAL_BITS):
  - Products are full 2*DATA_WIDTH, then arithmetic right shift by FRACTIONAL_BITS.
  - x², y²: saturate to the DATA_WIDTH signed max.
  - xy: truncate (wrap).
  - mag = x² + y², computed in DATA_WIDTH+1 bits (no overflow).
- Visit decision, in priority order:
  - If mag > r2 (unsigned compare): DONE, escaped=1, iter unchanged.
  - Else if iter < max_iter: x' = x²-y²+x0 and y' = 2·xy+y0 (both wrap); iter += 1; stay RUN.
  - Else: DONE, escaped=0, iter unchanged.
  - max_iter=0 finishes on the first visit with iter=1, escaped=0 unless it escapes.
- Output register:
  - Loads when it is empty, or when out_valid_o && out_ready_i at the same edge.
  - Source is the lowest-index context that was DONE before that edge; that context goes FREE.
  - Outputs hold stable while out_valid_o && !out_ready_i.
  - A context that reaches DONE is not visited again. It waits in DONE while the output register is stalled, and back-pressure propagates to in_ready_o.
- Ordering: results may leave out of order; tag_o identifies the pixel.
- Latency:
  - Number of visits per pixel = final iter_o.
  - NUM_CTX=1, output idle: out_valid_o rises after edge E+iter_o+1, where E is the accept edge.
  - General case: visits are spaced exactly NUM_CTX cycles apart.
- soft_clear_i: at the edge, all contexts go FREE and the output register is invalidated. It overrides a simultaneous accept, and the input is not consumed that cycle. The pointer is not reset.
- Simultaneous events: accept, visit and output-load act on different contexts in the same cycle without conflict. A context DONE at edge E is eligible for output-load from edge E+1.

Test Plan:
- NUM_CTX=1, c=(0,0), max_iter=20, r2=4.0 -> iter_o=20, escaped_o=0; out_valid_o after edge E+21.
- NUM_CTX=1, c=(2.0,2.0), r2=4.0 -> first visit mag=8 > 4: iter_o=1, escaped_o=1, out_valid_o after edge E+2.
- c=(1.0,0), max_iter=50, r2=4.0 -> z: 1, 2 (mag 4 not > 4), 5 -> iter_o=3, escaped_o=1. c=(-2.0,0) -> fixed point at 2: iter_o=50, escaped_o=0.
- NUM_CTX=4, tags 0..3 with c=(0,0),(2,2),(1,0),(2,2) and max_iter=8:
  - Results leave in order tag1, tag3, tag2, tag0 with iter_o 1, 1, 3, 8.
  - in_ready_o=0 while all 4 contexts are busy.
- Hold out_ready_i=0 with 4 pixels loaded -> all finish and stay DONE; in_ready_o=0; outputs stable. Release -> exactly 4 handshakes, then in_ready_o=1.
- Midway: assert soft_clear_i for 1 cycle with in_valid_i=1 -> the next cycle shows out_valid_o=0, busy_o=0, no accept. Pulsing rst_i mid-run -> all outputs return to reset values immediately.
